// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for seq_restoring_divider.
//   in_valid/in_ready   operand pair handshake (dividend, divisor)
//   out_valid/out_ready result handshake (quotient, remainder, div_zero)
// slave modport is the divider side, master is the requester side.
interface seq_restoring_divider_if #(
   parameter int N_W = 8,
   parameter int D_W = 4
);
   logic           in_valid;
   logic           in_ready;
   logic [N_W-1:0] dividend;
   logic [D_W-1:0] divisor;
   logic           out_valid;
   logic           out_ready;
   logic [N_W-1:0] quotient;
   logic [D_W-1:0] remainder;
   logic           div_zero;

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero
   );

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero
   );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_restoring_divider_if.slave: operand handshake in,
//          quotient/remainder/div_zero result handshake out
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// CALC  | shifting/subtracting, one quotient bit per cycle
// DONE  | result held with out_valid high until out_ready
module seq_restoring_divider #(
   parameter int N_W = 8,
   parameter int D_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   seq_restoring_divider_if.slave  bus
);
   localparam int CNT_W = $clog2(N_W + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state;
   logic [N_W-1:0] n_work;
   logic [D_W-1:0] d_work;
   logic [D_W-1:0] r_work;
   logic [N_W-1:0] q_work;
   logic [CNT_W-1:0] count;

   logic           in_ready_q;
   logic           out_valid_q;
   logic [N_W-1:0] quotient_q;
   logic [D_W-1:0] remainder_q;
   logic           div_zero_q;

   // The partial remainder is always below the divisor, so it fits in D_W
   // bits between steps; only the shifted trial value needs the extra bit.
   logic [D_W:0]   trial;
   logic           fits;
   logic [D_W-1:0] r_next;
   logic [N_W-1:0] q_next;

   always_comb begin
      trial  = {r_work, n_work[N_W-1]};
      fits   = trial >= {1'b0, d_work};
      r_next = fits ? D_W'(trial - {1'b0, d_work}) : trial[D_W-1:0];
      q_next = {q_work[N_W-2:0], fits};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         n_work      <= '0;
         d_work      <= '0;
         r_work      <= '0;
         q_work      <= '0;
         count       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  n_work     <= bus.dividend;
                  d_work     <= bus.divisor;
                  in_ready_q <= 1'b0;
                  if (bus.divisor != '0) begin
                     r_work <= '0;
                     q_work <= '0;
                     count  <= CNT_W'(N_W);
                     state  <= CALC;
                  end else begin
                     quotient_q  <= '1;
                     remainder_q <= '0;
                     div_zero_q  <= 1'b1;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            CALC: begin
               r_work <= r_next;
               q_work <= q_next;
               n_work <= n_work << 1;
               count  <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  quotient_q  <= q_next;
                  remainder_q <= r_next;
                  div_zero_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  div_zero_q  <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.div_zero  = div_zero_q;
endmodule
